// File: rtl/ustc_psum_acc.sv
// ustc_psum_acc: reduces sparse product lanes per row and accumulates them over the K-tile beats of one column.
// USTC_PSUM_SAT_EN: when defined, accumulator updates saturate to the signed range instead of wrapping.
module ustc_psum_acc #(
  parameter int NUM_IN  = 32,
  parameter int NUM_ROW = 16,
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 4,
  parameter int DW_CTRL = 4,
  parameter int DW_COL  = 4,
  parameter int DW_ACC  = 16,
  parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [DW_COL-1:0]         col,
  input  logic [NUM_IN*DW_LINE-1:0] in,
  input  logic                      out_en,
  output logic                      out_valid,
  output logic [DW_COL-1:0]         out_col,
  output logic [NUM_ROW*DW_ACC-1:0] out,
  output logic                      err
);

  // Row sums are kept at full precision: data width plus lane-count growth plus sign.
  localparam int RSW = DW_DATA + $clog2(NUM_IN) + 1;
  localparam int SW  = ((DW_ACC > RSW) ? DW_ACC : RSW) + 1;

`ifdef USTC_PSUM_SAT_EN
  localparam logic signed [SW-1:0] SMAX = {{(SW-DW_ACC+1){1'b0}}, {(DW_ACC-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DW_ACC+1){1'b1}}, {(DW_ACC-1){1'b0}}};
`endif

  logic [NUM_ROW-1:0][DW_ACC-1:0] acc_q, acc_d, out_q, out_d;
  logic [NUM_ROW-1:0][RSW-1:0]    rowsum;
  logic                           group_open_q, group_open_d;
  logic                           out_valid_q, out_valid_d;
  logic                           err_q, err_d;
  logic [DW_COL-1:0]              col_q, col_d, out_col_q, out_col_d;
  logic                           accept;
  logic [DW_DATA-1:0]             lane_data;
  logic [DW_ROW-1:0]              lane_row;
  logic                           lane_vld;
  logic                           rsvd_unused;
  logic [SW-1:0]                  base, sum;

  assign in_ready  = !out_valid_q || out_en;
  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out       = out_q;
  assign err       = err_q;

  always_comb begin
    rowsum      = '0;
    lane_data   = '0;
    lane_row    = '0;
    lane_vld    = 1'b0;
    rsvd_unused = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      lane_data   = in[i*DW_LINE +: DW_DATA];
      lane_row    = in[i*DW_LINE+DW_DATA +: DW_ROW];
      lane_vld    = in[i*DW_LINE+DW_DATA+DW_ROW];
      rsvd_unused = rsvd_unused ^ (^in[i*DW_LINE+DW_DATA+DW_ROW+1 +: DW_CTRL-1]);
      if (lane_vld && (int'(lane_row) < NUM_ROW)) begin
        rowsum[lane_row] = rowsum[lane_row] + {{(RSW-DW_DATA){lane_data[DW_DATA-1]}}, lane_data};
      end
    end
  end

  always_comb begin
    accept       = in_valid && in_ready;
    acc_d        = acc_q;
    out_d        = out_q;
    group_open_d = group_open_q;
    col_d        = col_q;
    out_col_d    = out_col_q;
    err_d        = err_q;
    out_valid_d  = out_valid_q;
    base         = '0;
    sum          = '0;
    if (accept) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        // A group start discards whatever the accumulator held before.
        base = group_open_q ? {{(SW-DW_ACC){acc_q[r][DW_ACC-1]}}, acc_q[r]} : '0;
        sum  = base + {{(SW-RSW){rowsum[r][RSW-1]}}, rowsum[r]};
`ifdef USTC_PSUM_SAT_EN
        if ($signed(sum) > SMAX) begin
          acc_d[r] = {1'b0, {(DW_ACC-1){1'b1}}};
        end else if ($signed(sum) < SMIN) begin
          acc_d[r] = {1'b1, {(DW_ACC-1){1'b0}}};
        end else begin
          acc_d[r] = sum[DW_ACC-1:0];
        end
`else
        acc_d[r] = sum[DW_ACC-1:0];
`endif
      end
      if (group_open_q) begin
        if (col != col_q) begin
          err_d = 1'b1;
        end
      end else begin
        col_d = col;
      end
      if (in_last) begin
        out_d        = acc_d;
        out_col_d    = group_open_q ? col_q : col;
        group_open_d = 1'b0;
      end else begin
        group_open_d = 1'b1;
      end
    end
    if (accept && in_last) begin
      out_valid_d = 1'b1;
    end else if (out_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      out_q        <= '0;
      group_open_q <= 1'b0;
      col_q        <= '0;
      out_col_q    <= '0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      out_q        <= out_d;
      group_open_q <= group_open_d;
      col_q        <= col_d;
      out_col_q    <= out_col_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule
